// File: rtl/reg_write_arbiter.sv
// Shared write port for the 8-bit configuration register file, arbitrated
// round-robin between the I2C slave and the parallel input port.
module reg_write_arbiter #(
  parameter int REGCOUNT = 20,
  parameter int ADDR_W   = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i2c_req,
  input  logic [ADDR_W-1:0]       i2c_addr,
  input  logic [7:0]              i2c_data,
  output logic                    i2c_gnt,
  input  logic                    par_req,
  input  logic [ADDR_W-1:0]       par_addr,
  input  logic [7:0]              par_data,
  output logic                    par_gnt,
  output logic [8*REGCOUNT-1:0]   registers_packed,
  output logic                    addr_err,
  output logic [7:0]              collision_cnt
);

  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(REGCOUNT);

  typedef enum logic {OWNER_I2C = 1'b0, OWNER_PAR = 1'b1} owner_t;

  owner_t            rr_last;
  logic [7:0]        regs [REGCOUNT];
  logic              i2c_el;
  logic              par_el;
  logic              pick_i2c;
  logic              pick_par;
  logic              win_valid;
  logic              win_in_range;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0]        win_data;

  // A requester is blind for the cycle its grant is showing, so a held req
  // is not written twice.
  always_comb begin
    i2c_el       = i2c_req & ~i2c_gnt;
    par_el       = par_req & ~par_gnt;
    pick_i2c     = i2c_el & (~par_el | (rr_last == OWNER_PAR));
    pick_par     = par_el & ~pick_i2c;
    win_valid    = pick_i2c | pick_par;
    win_addr     = pick_par ? par_addr : i2c_addr;
    win_data     = pick_par ? par_data : i2c_data;
    win_in_range = {1'b0, win_addr} < REG_LIMIT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i2c_gnt       <= 1'b0;
      par_gnt       <= 1'b0;
      addr_err      <= 1'b0;
      collision_cnt <= 8'h00;
      rr_last       <= OWNER_PAR;
    end else begin
      i2c_gnt  <= pick_i2c;
      par_gnt  <= pick_par;
      addr_err <= win_valid & ~win_in_range;
      if (win_valid) begin
        rr_last <= pick_par ? OWNER_PAR : OWNER_I2C;
      end
      if (i2c_el && par_el && collision_cnt != 8'hFF) begin
        collision_cnt <= collision_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < REGCOUNT; k++) begin
        regs[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < REGCOUNT; k++) begin
        if (win_valid && win_in_range && win_addr == ADDR_W'(k)) begin
          regs[k] <= win_data;
        end
      end
    end
  end

  always_comb begin
    registers_packed = '0;
    for (int k = 0; k < REGCOUNT; k++) begin
      registers_packed[8*k +: 8] = regs[k];
    end
  end

endmodule
